sprite_anim_renderer: RTL
=========================

Name: sprite_anim_renderer

Overview:
- Parametrised successor to the fixed full-screen sprite ROM reader.
- Places one animated sprite at a runtime (pos_x, pos_y) inside the VGA raster and supports horizontal flip.
- Cycles through NUM_FRAMES frames stacked in one external synchronous ROM, in loop or one-shot mode.
- Treats palette index TRANSPARENT_IDX as see-through and composites the sprite over a caller-supplied background pixel; output is final 4:4:4 RGB.

Parameters:
SPRITE_W, 30, sprite width in pixels
SPRITE_H, 64, sprite height in pixels
NUM_FRAMES, 4, animation frames stacked in ROM, frame f at base f*SPRITE_W*SPRITE_H
FRAME_PERIOD, 6, video frames each animation frame is held (>=1)
IDX_W, 3, palette index width
TRANSPARENT_IDX, 0, palette index treated as transparent
ADDR_W, $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES), ROM address width

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video (display enabled)
frame_start  in  1  one-cycle pulse at the start of each video frame
pos_x  in  10  sprite top-left column
pos_y  in  10  sprite top-left row
flip_h  in  1  1 = mirror sprite horizontally
anim_en  in  1  1 = animation advances
one_shot  in  1  1 = stop on last frame; 0 = loop
anim_restart  in  1  pulse: return to frame 0 and PLAY
bg_red, bg_green, bg_blue  in  4 each  background pixel for the same DrawX/DrawY
rom_address  out  ADDR_W  address to external ROM (1-cycle read latency, posedge vga_clk)
rom_q  in  IDX_W  ROM data
pal_index  out  IDX_W  index to external combinational palette
pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index
red, green, blue  out  4 each  composited pixel
sprite_hit  out  1  registered; 1 when an opaque sprite pixel is output
anim_done  out  1  level; 1 in DONE state
frame_idx  out  $clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset: rom_address=0; red/green/blue=0; sprite_hit=0; anim_done=0; frame_idx=0; hold counter=0; state=PLAY; all pipeline registers 0.
- Stage 1 (registered):
  - 11-bit compare: in_box = DrawX>=pos_x && DrawX<pos_x+SPRITE_W && DrawY>=pos_y && DrawY<pos_y+SPRITE_H.
  - Sprites clipped at screen edges do not wrap.
  - rel_x=DrawX-pos_x; col = flip_h ? SPRITE_W-1-rel_x : rel_x.
  - rom_address = frame_idx*SPRITE_W*SPRITE_H + (DrawY-pos_y)*SPRITE_W + col, computed in ADDR_W bits.
  - If !in_box: rom_address=0.
  - Register in_box, blank and bg RGB alongside.
- Stage 2: rom_q valid; pal_index=rom_q (combinational from rom_q). in_box/blank/bg carried one more register.
- Stage 3 (registered output):
  - If !blank_d: RGB=0, sprite_hit=0.
  - Else if in_box_d && rom_q!=TRANSPARENT_IDX: RGB=pal_*, sprite_hit=1.
  - Else: RGB=bg_*_d, sprite_hit=0.
- Latency: DrawX/DrawY/blank/bg sampled at cycle N produce red/green/blue at posedge N+3. bg is delayed internally; the caller supplies it aligned with DrawX.
- Animation FSM, evaluated on frame_start only, except anim_restart:
  - PLAY:
    - If anim_en, hold counter increments.
    - When hold==FRAME_PERIOD-1: hold<=0 and advance frame.
    - Advancing from frame_idx==NUM_FRAMES-1: one_shot ? go to DONE and stay on last frame : wrap to 0.
  - PAUSE is implicit: while anim_en=0, hold and frame_idx are frozen and the state is unchanged.
  - DONE: frame_idx held at NUM_FRAMES-1; anim_done=1; frame_start ignored. If one_shot drops while in DONE, the state is still DONE until anim_restart.
  - anim_restart (any cycle, any state): frame_idx<=0, hold<=0, state<=PLAY. It has priority over a simultaneous frame_start.
- frame_idx changes only at frame_start or anim_restart, so there is no mid-frame tearing unless restart is pulsed mid-frame.
- pos_x/pos_y/flip_h are sampled every cycle; callers change them during vertical blanking.
- NUM_FRAMES==1: frame_idx is constant 0. In one-shot mode, DONE is entered at the first advance.
- reset_n assertion mid-line: outputs go to reset values immediately (asynchronous); the pipeline refills within 3 cycles of release.

Decomposition:
- Package sprite_pkg:
  - rgb4_t struct (r, g, b as 4 bits each)
  - anim_state_e enum {PLAY, DONE}
  - localparam PIPE_LAT=3
- Sub-module sprite_anim_ctrl: the FSM, hold counter and frame_idx, with outputs frame_idx and anim_done.
- The top module keeps address generation, the pipeline and compositing.

Test Plan:
- pos=(100,50), flip_h=0, ROM word = low bits of address:
  - DrawX=100, DrawY=50 gives rom_address=0; DrawX=129, DrawY=113 gives 1919.
  - RGB appears exactly 3 clocks after DrawX is presented.
- flip_h=1, same position: DrawX=100, DrawY=50 -> rom_address=29; DrawX=129 -> rom_address=0.
- Transparency:
  - rom_q=TRANSPARENT_IDX inside the box -> RGB equals bg delayed 3 cycles, sprite_hit=0.
  - Opaque index 5 -> RGB=palette[5], sprite_hit=1.
  - blank=0 -> RGB=0.
- Loop: anim_en=1, FRAME_PERIOD=6, NUM_FRAMES=4, 30 frame_start pulses:
  - frame_idx changes after the 6th, 12th, 18th and 24th pulses: 0->1->2->3->0.
  - In frame 2 at the sprite origin, rom_address=3840.
- One-shot plus restart:
  - one_shot=1: after 24 pulses frame_idx=3, anim_done=1; further pulses leave it unchanged.
  - anim_restart on the same cycle as frame_start -> frame_idx=0, anim_done=0.
- Reset and edges:
  - reset_n low mid-line -> all outputs 0 asynchronously.
  - pos_x=620, SPRITE_W=30: DrawX=639 is in-box with col=19; DrawX=0..9 is never in-box (no wrap).

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the animated sprite renderer
package sprite_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;
  typedef enum logic {PLAY, DONE} anim_state_e;
  localparam int PIPE_LAT = 3;
endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: animation frame sequencer with per-frame hold counter
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES   = 4,
  parameter int FRAME_PERIOD = 6,
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1,
  localparam int HW = FRAME_PERIOD > 1 ? $clog2(FRAME_PERIOD) : 1
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic          anim_en,
  input  logic          one_shot,
  input  logic          anim_restart,
  output logic [FW-1:0] frame_idx,
  output logic          anim_done
);
  anim_state_e   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          last_hold, last_frame;
  assign last_hold  = hold_q == HW'(FRAME_PERIOD - 1);
  assign last_frame = frame_q == FW'(NUM_FRAMES - 1);
  // state, hold counter and frame index registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PLAY;
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end
  // restart wins over everything; otherwise only an enabled frame_start in PLAY moves anything
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    if (anim_restart) begin
      state_d = PLAY;
      hold_d  = '0;
      frame_d = '0;
    end else if (frame_start && state_q == PLAY && anim_en) begin
      hold_d = last_hold ? '0 : hold_q + HW'(1);
      if (last_hold) begin
        state_d = last_frame && one_shot ? DONE : PLAY;
        frame_d = last_frame ? (one_shot ? frame_q : '0) : frame_q + FW'(1);
      end
    end
  end
  // outputs decoded from registered state
  always_comb begin
    anim_done = state_q == DONE;
    frame_idx = NUM_FRAMES > 1 ? frame_q : '0;
  end
endmodule

// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer: positioned, flippable, animated sprite composited over a background
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int SPRITE_W        = 30,
  parameter int SPRITE_H        = 64,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_PERIOD    = 6,
  parameter int IDX_W           = 3,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = $clog2(SPRITE_W * SPRITE_H * NUM_FRAMES),
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic              one_shot,
  input  logic              anim_restart,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit,
  output logic              anim_done,
  output logic [FW-1:0]     frame_idx
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_box_d, in_box1_q, in_box2_q, blank1_q, blank2_q, hit_q, hit_d;
  rgb4_t             bg1_q, bg2_q, rgb_q, rgb_d;
  logic [10:0]       x_end, y_end;
  logic [9:0]        rel_x, rel_y, col;
  sprite_anim_ctrl #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_PERIOD(FRAME_PERIOD)
  ) u_ctrl (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .one_shot    (one_shot),
    .anim_restart(anim_restart),
    .frame_idx   (frame_idx),
    .anim_done   (anim_done)
  );
  // box bounds use 11 bits so a sprite hanging off the right/bottom edge clips instead of wrapping
  always_comb begin
    x_end    = {1'b0, pos_x} + 11'(SPRITE_W);
    y_end    = {1'b0, pos_y} + 11'(SPRITE_H);
    in_box_d = DrawX >= pos_x && {1'b0, DrawX} < x_end && DrawY >= pos_y && {1'b0, DrawY} < y_end;
    rel_x    = DrawX - pos_x;
    rel_y    = DrawY - pos_y;
    col      = flip_h ? 10'(SPRITE_W - 1) - rel_x : rel_x;
    addr_d   = in_box_d ? ADDR_W'(32'(frame_idx) * 32'(SPRITE_W * SPRITE_H) + 32'(rel_y) * 32'(SPRITE_W) + 32'(col)) : '0;
  end
  // compositing uses rom_q directly, which is valid in the cycle after the address register
  always_comb begin
    pal_index = rom_q;
    hit_d     = blank2_q && in_box2_q && rom_q != IDX_W'(TRANSPARENT_IDX);
    rgb_d     = !blank2_q ? '0 : hit_d ? rgb4_t'{pal_red, pal_green, pal_blue} : bg2_q;
  end
  // three-stage pipeline: address, ROM read alignment, composited output
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      in_box1_q <= 1'b0;
      in_box2_q <= 1'b0;
      blank1_q  <= 1'b0;
      blank2_q  <= 1'b0;
      bg1_q     <= '0;
      bg2_q     <= '0;
      rgb_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      in_box1_q <= in_box_d;
      in_box2_q <= in_box1_q;
      blank1_q  <= blank;
      blank2_q  <= blank1_q;
      bg1_q     <= rgb4_t'{bg_red, bg_green, bg_blue};
      bg2_q     <= bg1_q;
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
    end
  end
  assign rom_address = addr_q;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
  assign sprite_hit  = hit_q;
endmodule
